// File: rtl/instruction_fetch.sv
// Instruction fetch unit: registered PC drives the ROM, fetched words are latched and issued one cycle later.
// Optional NOP-driven issue delay is enabled by defining IFETCH_NOP_DELAY_EN.

package ifetch_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
endpackage

module instruction_fetch (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  input  logic        iStall,
  input  logic        iBranchTaken,
  input  logic [15:0] iBranchTarget,
  output logic        oValid,
  output logic [3:0]  oOpcode,
  output logic [7:0]  oDestination,
  output logic [7:0]  oSourceAddr1,
  output logic [7:0]  oSourceAddr0,
  output logic [15:0] oImmediate,
  output logic [15:0] oPC
);

`ifdef IFETCH_NOP_DELAY_EN
  typedef enum logic [1:0] {IDLE, RUN, DELAY} state_t;
`else
  typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] pc_q;
  logic        issue;
  logic        redirect;
  logic        clr_valid;

`ifdef IFETCH_NOP_DELAY_EN
  logic [23:0] cnt_q;
  logic        load_cnt;
  logic        dec_cnt;
`endif

  // oAddress comes straight from a flop, so the ROM address never depends on inputs.
  assign oAddress = pc_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a value unassigned (no latch).
    state_d   = state_q;
    issue     = 1'b0;
    redirect  = 1'b0;
    clr_valid = 1'b0;
`ifdef IFETCH_NOP_DELAY_EN
    load_cnt  = 1'b0;
    dec_cnt   = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (iBranchTaken) begin
          redirect = 1'b1;
        end else if (!iStall) begin
          issue = 1'b1;
`ifdef IFETCH_NOP_DELAY_EN
          if (iInstruction[27:24] == ifetch_pkg::OP_NOP && |iInstruction[23:0]) begin
            load_cnt = 1'b1;
            state_d  = DELAY;
          end
`endif
        end
      end
`ifdef IFETCH_NOP_DELAY_EN
      DELAY: begin
        // The bubble is held invalid even while stalled; only the countdown freezes.
        clr_valid = 1'b1;
        if (iBranchTaken) begin
          redirect = 1'b1;
          state_d  = RUN;
        end else if (!iStall) begin
          dec_cnt = 1'b1;
          if (cnt_q == 24'd1) state_d = RUN;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every datapath register has a reset value; there is no storage array here to leave unreset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q         <= 16'h0000;
      oValid       <= 1'b0;
      oOpcode      <= 4'h0;
      oDestination <= 8'h00;
      oSourceAddr1 <= 8'h00;
      oSourceAddr0 <= 8'h00;
      oImmediate   <= 16'h0000;
      oPC          <= 16'h0000;
    end else if (redirect) begin
      pc_q   <= iBranchTarget;
      oValid <= 1'b0;
    end else if (issue) begin
      oOpcode      <= iInstruction[27:24];
      oDestination <= iInstruction[23:16];
      oSourceAddr1 <= iInstruction[15:8];
      oSourceAddr0 <= iInstruction[7:0];
      oImmediate   <= iInstruction[15:0];
      oPC          <= pc_q;
      oValid       <= 1'b1;
      pc_q         <= pc_q + 16'd1;
    end else if (clr_valid) begin
      oValid <= 1'b0;
    end
  end

`ifdef IFETCH_NOP_DELAY_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)         cnt_q <= 24'd0;
    else if (redirect) cnt_q <= 24'd0;
    else if (load_cnt) cnt_q <= iInstruction[23:0];
    else if (dec_cnt)  cnt_q <= cnt_q - 24'd1;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a queue-based behavioural model predicts every cycle's outputs.
// Delay-mode scenarios are compiled in when IFETCH_NOP_DELAY_EN is defined.

module tb_instruction_fetch;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic [15:0] iBranchTarget = 16'h0000;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDestination, oSourceAddr1, oSourceAddr0;
  logic [15:0] oImmediate, oPC;

  typedef struct packed {
    logic [15:0] addr;
    logic        valid;
    logic [3:0]  op;
    logic [7:0]  dst;
    logic [7:0]  s1;
    logic [7:0]  s0;
    logic [15:0] imm;
    logic [15:0] pc;
  } obs_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [27:0] rom [0:65535];
  obs_t        exp_q [$];

  // Reference model: fetch pointer, last issued record, remaining bubble cycles.
  bit          m_started;
  logic [15:0] m_pc;
  obs_t        m_out;
  int          m_wait;

  always #5 Clock = ~Clock;

  assign iInstruction = rom[oAddress];

  instruction_fetch dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
    .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oValid(oValid), .oOpcode(oOpcode), .oDestination(oDestination),
    .oSourceAddr1(oSourceAddr1), .oSourceAddr0(oSourceAddr0),
    .oImmediate(oImmediate), .oPC(oPC)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic obs_t dut_obs();
    return '{oAddress, oValid, oOpcode, oDestination, oSourceAddr1, oSourceAddr0, oImmediate, oPC};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o      = m_out;
    o.addr = m_pc;
    return o;
  endfunction

  task automatic model_reset();
    m_started = 1'b0;
    m_pc      = 16'h0000;
    m_out     = '0;
    m_wait    = 0;
  endtask

  task automatic model_step(input logic st, input logic br, input logic [15:0] tgt);
    logic [27:0] w;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (br) begin
      m_pc        = tgt;
      m_out.valid = 1'b0;
      m_wait      = 0;
    end else if (m_wait > 0) begin
      m_out.valid = 1'b0;
      if (!st) m_wait--;
    end else if (!st) begin
      w           = rom[m_pc];
      m_out.op    = w[27:24];
      m_out.dst   = w[23:16];
      m_out.s1    = w[15:8];
      m_out.s0    = w[7:0];
      m_out.imm   = w[15:0];
      m_out.pc    = m_pc;
      m_out.valid = 1'b1;
      m_pc        = m_pc + 16'd1;
`ifdef IFETCH_NOP_DELAY_EN
      if (w[27:24] == ifetch_pkg::OP_NOP) m_wait = int'(w[23:0]);
`endif
    end
  endtask

  task automatic step(input logic st, input logic br, input logic [15:0] tgt);
    @(negedge Clock);
    Reset         = 1'b0;
    iStall        = st;
    iBranchTaken  = br;
    iBranchTarget = tgt;
    model_step(st, br, tgt);
    exp_q.push_back(model_obs());
  endtask

  task automatic apply_reset();
    @(negedge Clock);
    Reset         = 1'b1;
    iStall        = 1'($urandom);
    iBranchTaken  = 1'($urandom);
    iBranchTarget = 16'($urandom);
    model_reset();
    #1 check("reset_outputs", {51'b0, dut_obs()}, {51'b0, model_obs()});
    repeat (2) begin
      @(negedge Clock);
      iStall       = 1'($urandom);
      iBranchTaken = 1'($urandom);
    end
  endtask

  // Monitor: one expected record per out-of-reset cycle, compared just after the edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge Clock);
      #1;
      cyc++;
      if (!Reset) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_underflow: got empty queue at cycle %0d required an entry", cyc);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("cycle%0d", cyc), {51'b0, dut_obs()}, {51'b0, e});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [27:0] w;
    logic        st, br;
    logic [15:0] tgt;
    for (int i = 0; i < 65536; i++) begin
      w = 28'($urandom);
`ifdef IFETCH_NOP_DELAY_EN
      if (w[27:24] == ifetch_pkg::OP_NOP) w[23:0] = 24'($urandom_range(0, 5));
`endif
      rom[i] = w;
    end

    apply_reset();

    // Straight-line issue of words 0..2, three stalled cycles at oPC=2, then resume at 3.
    repeat (4) step(1'b0, 1'b0, 16'h0000);
    repeat (3) step(1'b1, 1'b0, 16'h0000);
    repeat (2) step(1'b0, 1'b0, 16'h0000);

    // Branch wins over a simultaneous stall.
    step(1'b1, 1'b1, 16'h0010);
    repeat (2) step(1'b0, 1'b0, 16'h0000);

    // PC wraps from FFFF to 0000 without a bubble.
    step(1'b0, 1'b1, 16'hFFFF);
    repeat (3) step(1'b0, 1'b0, 16'h0000);

    // Random traffic with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2200) apply_reset();
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 4) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      step(st, br, tgt);
    end

`ifdef IFETCH_NOP_DELAY_EN
    // Long NOP bubble at address 0, extended by random stalls.
    rom[0] = {ifetch_pkg::OP_NOP, 24'd4000};
    apply_reset();
    repeat (2) step(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 6000 && m_wait > 0; i++)
      step(($urandom_range(0, 9) == 0), 1'b0, 16'h0000);
    repeat (3) step(1'b0, 1'b0, 16'h0000);

    // Reset in the middle of a bubble leaves nothing behind.
    rom[0] = {ifetch_pkg::OP_NOP, 24'd2000};
    apply_reset();
    repeat (2) step(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3000 && m_wait != 1234; i++) step(1'b0, 1'b0, 16'h0000);
    rom[0] = {4'h5, 24'h123456};
    apply_reset();
    repeat (5) step(1'b0, 1'b0, 16'h0000);
`endif

    @(posedge Clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
